// File: rtl/out_port_uart_tx_pkg.sv
// Shared definitions for the output-port UART transmitter: FSM encoding,
// 8N1 frame constants and the default bit period.
package out_port_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // 50 MHz system clock, 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/out_port_uart_tx_if.sv
// CPU output-port side of the UART transmitter: load strobe and register
// contents in, serial line and queue status out.
interface out_port_uart_tx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_AW    = 2
);
  logic                  out_wr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  txd;
  logic                  busy;
  logic                  fifo_full;
  logic [FIFO_AW:0]      fifo_count;
  logic                  overflow;

  modport master (
    output out_wr, out_data,
    input  txd, busy, fifo_full, fifo_count, overflow
  );

  modport slave (
    input  out_wr, out_data,
    output txd, busy, fifo_full, fifo_count, overflow
  );
endinterface

// File: rtl/out_port_fifo.sv
// Single-clock word FIFO; a push into a full FIFO is accepted only when a
// pop happens on the same edge.
module out_port_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/out_port_uart_tx.sv
// Captures each word loaded into the CPU output-port register and sends it
// as BYTES_PER_WORD 8N1 frames, LSB byte first, on a registered txd.
module out_port_uart_tx
  import out_port_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BYTES_PER_WORD = 4,
  parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH     = 4,
  parameter int FIFO_AW        = 2
) (
  input logic               clock,
  input logic               clear,
  out_port_uart_tx_if.slave bus
);

  localparam int BAUD_W = clog2_min1(CLKS_PER_BIT);
  localparam int BYTE_W = clog2_min1(BYTES_PER_WORD);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_MAX  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES_PER_WORD - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, fifo_dout;
  logic [BYTE_W-1:0]     byte_q, byte_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic                  txd_q, txd_d;
  logic                  wr_d_q, ovf_q;
  logic                  pop, baud_wrap;
  logic                  fifo_full, fifo_empty;
  logic [FIFO_AW:0]      fifo_count;

  // The output-port register shows the new word only after its load edge,
  // so the push happens one cycle after out_wr is sampled.
  out_port_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clock (clock),
    .clear (clear),
    .push  (wr_d_q),
    .pop   (pop),
    .din   (bus.out_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign baud_wrap = (baud_q == BAUD_MAX);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    baud_d  = baud_wrap ? '0 : baud_q + 1'b1;
    pop     = 1'b0;
    txd_d   = STOP_BIT;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          byte_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: if (baud_wrap) state_d = DATA;
      DATA: if (baud_wrap) begin
        if (bit_q == BIT_LAST) begin
          bit_d   = '0;
          state_d = STOP;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      STOP: if (baud_wrap) begin
        if (byte_q == BYTE_LAST) begin
          state_d = IDLE;
        end else begin
          byte_d  = byte_q + 1'b1;
          state_d = START;
        end
      end
      default: state_d = IDLE;
    endcase
    // Line level is decoded from the next state so txd leaves a flop.
    case (state_d)
      START:   txd_d = START_BIT;
      DATA:    txd_d = shift_d[{byte_d, bit_d}];
      default: txd_d = STOP_BIT;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      shift_q <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      txd_q   <= 1'b1;
      wr_d_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      txd_q   <= txd_d;
      wr_d_q  <= bus.out_wr;
      if (wr_d_q && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  assign bus.txd        = txd_q;
  assign bus.busy       = !fifo_empty || (state_q != IDLE);
  assign bus.fifo_full  = fifo_full;
  assign bus.fifo_count = fifo_count;
  assign bus.overflow   = ovf_q;

endmodule

// File: doc/out_port_uart_tx.md
Name: out_port_uart_tx

Overview:
- Downstream consumer of the CPU output-port register.
- Watches the output-port load enable and captures each newly loaded word into a small FIFO.
- Serialises each word as BYTES_PER_WORD 8N1 UART frames, LSB byte first, on txd, so software `out` instructions reach a host terminal.
- Decouples CPU write rate from line rate; excess writes are dropped and flagged.

Parameters:
- DATA_WIDTH, 32, width of the output-port word.
- BYTES_PER_WORD, 4, bytes sent per word; must equal DATA_WIDTH/8.
- CLKS_PER_BIT, 434, clocks per UART bit (50 MHz / 115200); minimum 2.
- FIFO_DEPTH, 4, word entries; power of two, minimum 2.
- FIFO_AW, 2, log2(FIFO_DEPTH).

Ports:
- clock  in  1  system clock; all state on its rising edge.
- clear  in  1  asynchronous active-low reset.
- out_wr  in  1  output-port load enable, same signal that loads the output-port register.
- out_data  in  DATA_WIDTH  output-port register contents.
- txd  out  1  serial line, idle high, registered.
- busy  out  1  high while the FIFO is non-empty or the FSM is not IDLE.
- fifo_full  out  1  FIFO holds FIFO_DEPTH words.
- fifo_count  out  FIFO_AW+1  words currently queued.
- overflow  out  1  sticky: a captured word was dropped.

Behaviour:
- Reset: clear low forces all state immediately, without waiting for a clock edge.
  - txd=1, busy=0, fifo_full=0, fifo_count=0, overflow=0, FSM=IDLE.
  - FIFO pointers are zeroed.
  - A frame in flight is truncated; no resume after reset.
- Capture:
  - wr_d is out_wr registered one cycle, because the register's new value is visible only after the load edge.
  - When wr_d=1, out_data is pushed.
  - The push is accepted if not full, or if a pop occurs on the same edge.
  - Otherwise the word is dropped, overflow is set, and fifo_count is unchanged.
  - Consecutive out_wr cycles each push a word.
- overflow clears only on reset.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If the FIFO is non-empty, pop the head into shift_word, set byte_idx=0, bit_cnt=0, baud_cnt=0, and go to START.
  - START: txd=0 for CLKS_PER_BIT clocks, then go to DATA.
  - DATA: txd = current byte bit bit_cnt, where current byte = shift_word[8*byte_idx +: 8]. Each bit lasts CLKS_PER_BIT clocks. After bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT clocks. Then:
    - if byte_idx < BYTES_PER_WORD-1, increment byte_idx and go to START with no idle gap;
    - else go to IDLE.
- baud_cnt counts 0..CLKS_PER_BIT-1 and wraps; a state or bit advances on the wrap.
- Timing:
  - Edge E0 samples out_wr=1 (register loads).
  - E1 pushes the word.
  - E2 pops it; txd falls after E2.
  - Word duration is BYTES_PER_WORD*10*CLKS_PER_BIT clocks.
  - Exactly one IDLE cycle separates consecutive queued words.
- Simultaneous push and pop: both are performed, and fifo_count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from fifo_count.
- txd is glitch-free: it is driven from a flop, not decoded combinationally.

Decomposition:
- Shared package/include holds:
  - FSM state encoding (2-bit: IDLE=0, START=1, DATA=2, STOP=3);
  - the UART frame constants (start bit 0, stop bit 1, 8 data bits);
  - the default CLKS_PER_BIT.
- One sub-module, out_port_fifo: synchronous single-clock word FIFO with push, pop, full, empty and count, plus the same asynchronous active-low clear.
- The FSM, baud counter and capture logic stay in out_port_uart_tx.

Test Plan:
- Common settings: CLKS_PER_BIT=4, FIFO_DEPTH=4.
- Single word: pulse out_wr with out_data=32'h44332211.
  - txd falls 2 cycles after the sampling edge.
  - Bytes decode as 11,22,33,44, LSB bit first, each with start=0 and stop=1.
  - Total 160 clocks; busy then drops to 0.
- Burst of six consecutive out_wr cycles, words 1..6:
  - word 1 is popped immediately and words 2..5 queue (fifo_count=4, fifo_full=1);
  - word 6 is dropped and overflow=1;
  - the line carries words 1..5 in order;
  - overflow stays 1 afterwards.
- Back-to-back queued words: exactly 1 clock of txd=1 between the last stop bit of word N and the start bit of word N+1.
- Push with simultaneous pop: with the FIFO full and the FSM in the final STOP of a word, time out_wr so that the push coincides with the IDLE pop.
  - The push is accepted, fifo_count stays 4, and overflow stays 0.
- Reset mid-frame: assert clear low between clock edges during DATA bit 3 of byte 1.
  - txd=1, fifo_count=0, busy=0 and overflow=0 immediately, without a clock edge.
  - After release, a new write transmits cleanly from its start bit.
- Idle: after reset, with no writes for 100 clocks, txd=1 and busy=0 throughout.
